sbox_switch: RTL and testbench

- Four-port (N/W/S/E) routing switch box for one CGRA tile boundary.
- Each 32-bit output is driven by a statically configured choice of one of the four inputs, or constant zero.
- Outputs are registered, giving one cycle of latency.
- The block sits between neighbouring PE tiles and carries data words only; there is no handshake.

---
 rtl/sbox_pkg.sv | 15 +
 rtl/sbox_switch_if.sv | 29 ++
 rtl/sbox_port_mux.sv | 55 +++++
 rtl/sbox_switch.sv | 76 +++++++
 tb/tb_sbox_switch.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/sbox_pkg.sv
// Shared definitions for the CGRA tile-boundary switch box: direction
// indices used as mux selects, the select type and the default data width.
package sbox_pkg;

  typedef logic [2:0] sel_t;

  localparam sel_t DIR_N    = 3'd0;
  localparam sel_t DIR_W    = 3'd1;
  localparam sel_t DIR_S    = 3'd2;
  localparam sel_t DIR_E    = 3'd3;
  localparam sel_t SEL_ZERO = 3'd4;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/sbox_switch_if.sv
// Data bundle between a switch box and its four neighbouring tiles.
// The neighbour side (master) drives the inputs and sees the outputs;
// the switch side (slave) does the opposite. There is no handshake.
import sbox_pkg::*;

interface sbox_switch_if #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] inorth;
  logic [WIDTH-1:0] iwest;
  logic [WIDTH-1:0] isouth;
  logic [WIDTH-1:0] ieast;
  logic [WIDTH-1:0] onorth;
  logic [WIDTH-1:0] owest;
  logic [WIDTH-1:0] osouth;
  logic [WIDTH-1:0] oeast;

  modport master (
    output inorth, iwest, isouth, ieast,
    input  onorth, owest, osouth, oeast
  );

  modport slave (
    input  inorth, iwest, isouth, ieast,
    output onorth, owest, osouth, oeast
  );

endinterface

// File: rtl/sbox_port_mux.sv
// One output port of the switch box: a statically selected 5-way mux
// (four directions or zero) followed by an optional output register.
import sbox_pkg::*;

module sbox_port_mux #(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL        = 0,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_north,
  input  logic [WIDTH-1:0] i_west,
  input  logic [WIDTH-1:0] i_south,
  input  logic [WIDTH-1:0] i_east,
  output logic [WIDTH-1:0] o_data
);

  localparam sel_t C_SEL = sel_t'(SEL);

  logic [WIDTH-1:0] w_mux;

  // Pick the configured source; any select of 4 or above yields zero.
  always_comb begin
    w_mux = '0;
    case (C_SEL)
      DIR_N:   w_mux = i_north;
      DIR_W:   w_mux = i_west;
      DIR_S:   w_mux = i_south;
      DIR_E:   w_mux = i_east;
      default: w_mux = '0;
    endcase
  end

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] r_data;

    // Output register; a low reset sampled at the edge clears it.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_data <= '0;
      end else begin
        r_data <= w_mux;
      end
    end

    assign o_data = r_data;
  end else begin : g_comb
    // Pass-through build: clock and reset have no role here.
    logic w_unused;
    assign w_unused = clk ^ reset;
    assign o_data   = w_mux;
  end

endmodule

// File: rtl/sbox_switch.sv
// Four-port switch box for one CGRA tile boundary. Each output is an
// independent statically configured mux over the four inputs (or zero),
// so multicast and U-turn routes fall out naturally. All ports share the
// same clock edge and reset.
import sbox_pkg::*;

module sbox_switch #(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL_NORTH  = 2,
  parameter int SEL_WEST   = 3,
  parameter int SEL_SOUTH  = 0,
  parameter int SEL_EAST   = 1,
  parameter int REGISTERED = 1
) (
  input  logic         clk,
  input  logic         reset,
  sbox_switch_if.slave bus
);

  sbox_port_mux #(
    .WIDTH      (WIDTH),
    .SEL        (SEL_NORTH),
    .REGISTERED (REGISTERED)
  ) u_north (
    .clk     (clk),
    .reset   (reset),
    .i_north (bus.inorth),
    .i_west  (bus.iwest),
    .i_south (bus.isouth),
    .i_east  (bus.ieast),
    .o_data  (bus.onorth)
  );

  sbox_port_mux #(
    .WIDTH      (WIDTH),
    .SEL        (SEL_WEST),
    .REGISTERED (REGISTERED)
  ) u_west (
    .clk     (clk),
    .reset   (reset),
    .i_north (bus.inorth),
    .i_west  (bus.iwest),
    .i_south (bus.isouth),
    .i_east  (bus.ieast),
    .o_data  (bus.owest)
  );

  sbox_port_mux #(
    .WIDTH      (WIDTH),
    .SEL        (SEL_SOUTH),
    .REGISTERED (REGISTERED)
  ) u_south (
    .clk     (clk),
    .reset   (reset),
    .i_north (bus.inorth),
    .i_west  (bus.iwest),
    .i_south (bus.isouth),
    .i_east  (bus.ieast),
    .o_data  (bus.osouth)
  );

  sbox_port_mux #(
    .WIDTH      (WIDTH),
    .SEL        (SEL_EAST),
    .REGISTERED (REGISTERED)
  ) u_east (
    .clk     (clk),
    .reset   (reset),
    .i_north (bus.inorth),
    .i_west  (bus.iwest),
    .i_south (bus.isouth),
    .i_east  (bus.ieast),
    .o_data  (bus.oeast)
  );

endmodule

// File: tb/tb_sbox_switch.sv
// Testbench for sbox_switch. Three instances share the same stimulus:
//   A - default routing, registered
//   B - multicast / zero variant (1,1,4,3), registered
//   C - default routing, combinational pass-through
// Expected values come from a direction-indexed routing table.
module tb_sbox_switch;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rstN;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Select tables indexed by output direction: 0=N, 1=W, 2=S, 3=E
  int selA [4] = '{2, 3, 0, 1};
  int selB [4] = '{1, 1, 4, 3};
  int selC [4] = '{2, 3, 0, 1};
  string dirName [4] = '{"north", "west", "south", "east"};

  logic [W-1:0] inVec [4];
  logic [W-1:0] expA  [4];
  logic [W-1:0] expB  [4];

  sbox_switch_if #(.WIDTH(W)) ifA ();
  sbox_switch_if #(.WIDTH(W)) ifB ();
  sbox_switch_if #(.WIDTH(W)) ifC ();

  sbox_switch #(
    .WIDTH(W), .SEL_NORTH(2), .SEL_WEST(3), .SEL_SOUTH(0), .SEL_EAST(1), .REGISTERED(1)
  ) dutA (.clk(clk), .reset(rstN), .bus(ifA.slave));

  sbox_switch #(
    .WIDTH(W), .SEL_NORTH(1), .SEL_WEST(1), .SEL_SOUTH(4), .SEL_EAST(3), .REGISTERED(1)
  ) dutB (.clk(clk), .reset(rstN), .bus(ifB.slave));

  sbox_switch #(
    .WIDTH(W), .SEL_NORTH(2), .SEL_WEST(3), .SEL_SOUTH(0), .SEL_EAST(1), .REGISTERED(0)
  ) dutC (.clk(clk), .reset(rstN), .bus(ifC.slave));

  always #5 clk = ~clk;

  // Route model: a select below 4 names an input direction, anything else is zero
  function automatic logic [W-1:0] route(input int sel, input logic [W-1:0] v [4]);
    if (sel < 4) return v[sel];
    return '0;
  endfunction

  task automatic compare(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] w,
                               input logic [W-1:0] s, input logic [W-1:0] e);
    inVec = '{n, w, s, e};
    ifA.inorth = n; ifA.iwest = w; ifA.isouth = s; ifA.ieast = e;
    ifB.inorth = n; ifB.iwest = w; ifB.isouth = s; ifB.ieast = e;
    ifC.inorth = n; ifC.iwest = w; ifC.isouth = s; ifC.ieast = e;
    #1;
  endtask

  // Advance one rising edge; registered models capture what the edge sees
  task automatic clockEdge();
    logic [W-1:0] nextA [4];
    logic [W-1:0] nextB [4];
    for (int d = 0; d < 4; d++) begin
      nextA[d] = rstN ? route(selA[d], inVec) : '0;
      nextB[d] = rstN ? route(selB[d], inVec) : '0;
    end
    @(posedge clk);
    expA = nextA;
    expB = nextB;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [W-1:0] obsA [4];
    logic [W-1:0] obsB [4];
    logic [W-1:0] obsC [4];
    obsA = '{ifA.onorth, ifA.owest, ifA.osouth, ifA.oeast};
    obsB = '{ifB.onorth, ifB.owest, ifB.osouth, ifB.oeast};
    obsC = '{ifC.onorth, ifC.owest, ifC.osouth, ifC.oeast};
    for (int d = 0; d < 4; d++) begin
      compare($sformatf("%s.A.%s", tag, dirName[d]), obsA[d], expA[d]);
      compare($sformatf("%s.B.%s", tag, dirName[d]), obsB[d], expB[d]);
      compare($sformatf("%s.C.%s", tag, dirName[d]), obsC[d], route(selC[d], inVec));
    end
  endtask

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges with the reference inputs
    rstN = 1'b0;
    applyStimulus(32'd100, 32'd200, 32'd300, 32'd400);
    clockEdge();
    clockEdge();
    checkOutput("reset");
    compare("reset.A.north.const", ifA.onorth, 32'd0);

    // Default routing after release, held over several cycles
    rstN = 1'b1;
    clockEdge();
    checkOutput("default");
    compare("default.A.north.const", ifA.onorth, 32'd300);
    compare("default.A.west.const",  ifA.owest,  32'd400);
    compare("default.A.south.const", ifA.osouth, 32'd100);
    compare("default.A.east.const",  ifA.oeast,  32'd200);
    compare("variant.B.north.const", ifB.onorth, 32'd200);
    compare("variant.B.west.const",  ifB.owest,  32'd200);
    compare("variant.B.south.const", ifB.osouth, 32'd0);
    compare("variant.B.east.const",  ifB.oeast,  32'd400);
    for (int i = 0; i < 4; i++) begin
      clockEdge();
      checkOutput("hold");
    end

    // One-cycle latency on a single input change
    applyStimulus(32'd555, 32'd200, 32'd300, 32'd400);
    checkOutput("latency.before");
    compare("latency.A.south.old", ifA.osouth, 32'd100);
    compare("latency.C.south.new", ifC.osouth, 32'd555);
    clockEdge();
    checkOutput("latency.after");
    compare("latency.A.south.new", ifA.osouth, 32'd555);

    // Mid-run reset pulse, then recovery with the reference inputs
    applyStimulus(32'd100, 32'd200, 32'd300, 32'd400);
    rstN = 1'b0;
    clockEdge();
    checkOutput("midreset");
    compare("midreset.A.west.const", ifA.owest, 32'd0);
    rstN = 1'b1;
    clockEdge();
    checkOutput("recover");
    compare("recover.A.west.const", ifA.owest, 32'd400);

    // Reset held low: pass-through still follows toggling inputs
    rstN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h1111_0000 + i, 32'h2222_0000 + i, 32'h3333_0000 + i, 32'h4444_0000 + i);
      checkOutput("heldreset.pre");
      clockEdge();
      checkOutput("heldreset.post");
    end
    rstN = 1'b1;

    // Randomized inputs with occasional reset
    for (int i = 0; i < 40; i++) begin
      rstN = ($urandom_range(0, 9) != 0);
      applyStimulus($urandom, $urandom, $urandom, $urandom);
      checkOutput("random.pre");
      clockEdge();
      checkOutput("random.post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
